// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- fetch-stage sequencer for the pipelined RV32I core.
//
// Drives the PC register's next-PC and hold inputs, runs the req/ack
// handshake to instruction memory, and applies trap/branch redirects and
// hazard stalls. It delivers fetched instructions to the IF/ID boundary.
//
// Parameters:
//   WIDTH     instruction address width (defaults to `I_ADD_SIZE)
//   TRAP_VEC  trap redirect target (word aligned)
//
// Ports:
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_pc                     current PC from the PC register
//   o_nxt_pc, o_pc_stall     next PC / hold to the PC register (combinational)
//   i_stall                  hazard-unit stall (IF/ID cannot accept)
//   i_redirect_valid/_pc     taken branch/jump from EX
//   i_trap_valid             trap redirect to TRAP_VEC
//   o_imem_req, o_imem_addr  fetch request / latched fetch address
//   i_imem_ack, i_imem_rdata fetch completion and instruction word
//   o_if_valid/_instr/_pc    registered IF/ID entry
//   o_stall_cnt, o_flush_cnt perf counters
//
// Optional feature: define FETCH_PERF_CNT_EN to build the saturating
// stall/flush counters; otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
`ifndef I_ADD_SIZE
`define I_ADD_SIZE 32
`endif

module fetch_ctrl #(
    parameter int               WIDTH    = `I_ADD_SIZE,
    parameter logic [WIDTH-1:0] TRAP_VEC = '0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_nxt_pc,
    output logic             o_pc_stall,
    input  logic             i_stall,
    input  logic             i_redirect_valid,
    input  logic [WIDTH-1:0] i_redirect_pc,
    input  logic             i_trap_valid,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic             o_if_valid,
    output logic [31:0]      o_if_instr,
    output logic [WIDTH-1:0] o_if_pc,
    output logic [31:0]      o_stall_cnt,
    output logic [31:0]      o_flush_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_KILL  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] addr_reg;
    logic [31:0]      buf_instr_reg;
    logic [WIDTH-1:0] buf_pc_reg;
    logic             if_valid_reg;
    logic [31:0]      if_instr_reg;
    logic [WIDTH-1:0] if_pc_reg;

    logic             req_c;
    logic             ack_c;
    logic             flush_c;
    logic             pc_stall_c;
    logic [WIDTH-1:0] nxt_pc_c;
    logic [WIDTH-1:0] seq_pc_c;
    logic [WIDTH-1:0] redirect_tgt_c;
    logic             if_from_mem_c;
    logic             if_from_buf_c;
    logic             if_bubble_c;
    logic             buf_load_c;
    logic             addr_load_c;

    // Low target bits are discarded by the alignment mask.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = &{1'b0, i_redirect_pc[1:0]};

    always_comb begin
        req_c          = (state_reg == ST_FETCH) || (state_reg == ST_KILL);
        ack_c          = i_imem_ack && req_c;
        flush_c        = (state_reg != ST_BOOT) && (i_trap_valid || i_redirect_valid);
        seq_pc_c       = i_pc + WIDTH'(4);
        redirect_tgt_c = {i_redirect_pc[WIDTH-1:2], 2'b00};

        pc_stall_c     = 1'b1;
        nxt_pc_c       = seq_pc_c;
        state_next     = state_reg;
        if_from_mem_c  = 1'b0;
        if_from_buf_c  = 1'b0;
        if_bubble_c    = 1'b0;
        buf_load_c     = 1'b0;

        if (flush_c) begin
            // Trap beats redirect; both beat stall. An unacked request
            // cannot be withdrawn, so it is drained in KILL.
            pc_stall_c  = 1'b0;
            nxt_pc_c    = i_trap_valid ? TRAP_VEC : redirect_tgt_c;
            if_bubble_c = 1'b1;
            state_next  = (req_c && !ack_c) ? ST_KILL : ST_FETCH;
        end else begin
            unique case (state_reg)
                ST_BOOT: begin
                    state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (ack_c) begin
                        if (i_stall) begin
                            buf_load_c = 1'b1;
                            state_next = ST_HOLD;
                        end else begin
                            pc_stall_c    = 1'b0;
                            if_from_mem_c = 1'b1;
                        end
                    end else if (!i_stall) begin
                        if_bubble_c = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!i_stall) begin
                        pc_stall_c    = 1'b0;
                        if_from_buf_c = 1'b1;
                        state_next    = ST_FETCH;
                    end
                end
                ST_KILL: begin
                    if_bubble_c = 1'b1;
                    if (ack_c) begin
                        state_next = ST_FETCH;
                    end
                end
                default: begin
                    state_next = ST_BOOT;
                end
            endcase
        end

        // A new request starts whenever FETCH is entered or the current one
        // completes in FETCH; its address is whatever the PC will hold then.
        addr_load_c = (state_next == ST_FETCH) && ((state_reg != ST_FETCH) || ack_c);
    end

    assign o_imem_req  = i_rstn && req_c;
    assign o_pc_stall  = !i_rstn || pc_stall_c;
    assign o_nxt_pc    = i_rstn ? nxt_pc_c : '0;
    assign o_imem_addr = addr_reg;
    assign o_if_valid  = if_valid_reg;
    assign o_if_instr  = if_instr_reg;
    assign o_if_pc     = if_pc_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg     <= ST_BOOT;
            addr_reg      <= '0;
            buf_instr_reg <= NOP;
            buf_pc_reg    <= '0;
            if_valid_reg  <= 1'b0;
            if_instr_reg  <= NOP;
            if_pc_reg     <= '0;
        end else begin
            state_reg <= state_next;

            if (addr_load_c) begin
                addr_reg <= pc_stall_c ? i_pc : nxt_pc_c;
            end

            if (buf_load_c) begin
                buf_instr_reg <= i_imem_rdata;
                buf_pc_reg    <= addr_reg;
            end

            if (if_bubble_c) begin
                if_valid_reg <= 1'b0;
            end else if (if_from_mem_c) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= i_imem_rdata;
                if_pc_reg    <= addr_reg;
            end else if (if_from_buf_c) begin
                if_valid_reg <= 1'b1;
                if_instr_reg <= buf_instr_reg;
                if_pc_reg    <= buf_pc_reg;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (pc_stall_c && (state_reg != ST_BOOT) && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (flush_c && (flush_cnt_reg != '1)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_reg;
    assign o_flush_cnt = flush_cnt_reg;
`else
    assign o_stall_cnt = '0;
    assign o_flush_cnt = '0;
`endif

endmodule
